// File: rtl/scr_pkg.sv
// Shared constants for the x^58+x^39+1 self-synchronous lane scrambler.
package scr_pkg;

  localparam int unsigned SCR_STATE_W = 58;
  localparam int unsigned SCR_TAP_A   = 39;
  localparam int unsigned SCR_TAP_B   = 58;

  localparam logic [SCR_STATE_W-1:0] SCR_DEFAULT_SEED = 58'h3FF_FFFF_FFFF_FFFF;

  typedef enum logic {
    SCR_MODE_SCRAMBLE   = 1'b0,
    SCR_MODE_DESCRAMBLE = 1'b1
  } scr_mode_e;

endpackage

// File: rtl/scr_lane_core.sv
// One lane: combinational x^58+x^39+1 scramble/descramble over a beat plus the 58-bit state.
// SCR_SEED_LOAD_EN adds a synchronous seed override of the state.
module scr_lane_core
  import scr_pkg::*;
#(
  parameter int unsigned             LANE_W     = 64,
  parameter logic [SCR_STATE_W-1:0]  RESET_SEED = SCR_DEFAULT_SEED
) (
  input  logic                   clk,
  input  logic                   reset,
`ifdef SCR_SEED_LOAD_EN
  input  logic                   seed_load,
  input  logic [SCR_STATE_W-1:0] seed_value,
`endif
  input  logic                   accept,
  input  logic                   active,
  input  logic                   mode,
  input  logic [LANE_W-1:0]      in_data,
  output logic [LANE_W-1:0]      out_data
);

  localparam int unsigned HistW = LANE_W + SCR_STATE_W;

  logic [SCR_STATE_W-1:0] state_q, state_d;
  logic [HistW-1:0]       hist;
  logic [LANE_W-1:0]      scr;

  // hist[j+58] is stream bit h(j); the low 58 bits hold the previous beat's tail, oldest at 0.
  always_comb begin
    hist    = '0;
    scr     = '0;
    state_d = state_q;
    for (int k = 0; k < SCR_STATE_W; k++) begin
      hist[SCR_STATE_W-1-k] = state_q[k];
    end
    for (int i = 0; i < LANE_W; i++) begin
      scr[i] = in_data[i] ^ hist[i+SCR_STATE_W-SCR_TAP_A] ^ hist[i+SCR_STATE_W-SCR_TAP_B];
      hist[i+SCR_STATE_W] = (mode == SCR_MODE_DESCRAMBLE) ? in_data[i] : scr[i];
    end
    for (int k = 0; k < SCR_STATE_W; k++) begin
      state_d[k] = hist[HistW-1-k];
    end
  end

  assign out_data = active ? scr : in_data;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RESET_SEED;
`ifdef SCR_SEED_LOAD_EN
    end else if (seed_load) begin
      state_q <= seed_value;
`endif
    end else if (accept && active) begin
      state_q <= state_d;
    end
  end

endmodule

// File: rtl/multi_lane_scrambler.sv
// NUM_LANES independent x^58+x^39+1 scramblers behind a one-stage valid/ready register.
// SCR_SEED_LOAD_EN adds seed_load/seed_value ports to force every lane state.
module multi_lane_scrambler
  import scr_pkg::*;
#(
  parameter int unsigned            NUM_LANES  = 4,
  parameter int unsigned            LANE_W     = 64,
  parameter logic [SCR_STATE_W-1:0] RESET_SEED = SCR_DEFAULT_SEED
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          in_enable,
  input  logic                          mode,
  input  logic [NUM_LANES-1:0]          lane_mask,
  input  logic [NUM_LANES*LANE_W-1:0]   in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic [NUM_LANES*LANE_W-1:0]   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
`ifdef SCR_SEED_LOAD_EN
  input  logic                          seed_load,
  input  logic [SCR_STATE_W-1:0]        seed_value,
`endif
  input  logic                          in_idle,
  output logic                          out_idle
);

  logic                        accept;
  logic [NUM_LANES*LANE_W-1:0] lane_out;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign out_idle = in_idle;

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    scr_lane_core #(
      .LANE_W     (LANE_W),
      .RESET_SEED (RESET_SEED)
    ) u_lane (
      .clk        (clk),
      .reset      (reset),
`ifdef SCR_SEED_LOAD_EN
      .seed_load  (seed_load),
      .seed_value (seed_value),
`endif
      .accept     (accept),
      .active     (in_enable && lane_mask[g]),
      .mode       (mode),
      .in_data    (in_data[g*LANE_W +: LANE_W]),
      .out_data   (lane_out[g*LANE_W +: LANE_W])
    );
  end

  // out_data deliberately keeps its last value when the register drains.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      out_data  <= lane_out;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_multi_lane_scrambler.sv
// Directed/random bench for multi_lane_scrambler against a bit-serial reference model.
module tb_multi_lane_scrambler;

  localparam int unsigned NL = 4;
  localparam int unsigned W  = 64;
  localparam int unsigned DW = NL * W;
  localparam logic [57:0] SEED = 58'h3FF_FFFF_FFFF_FFFF;
  localparam int NBEATS = 1000;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_enable = 1'b1;
  logic          mode = 1'b0;
  logic [NL-1:0] lane_mask = '1;
  logic [DW-1:0] in_data = '0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b1;
  logic          in_idle = 1'b0;
  logic          in_ready, out_valid, out_idle;
  logic [DW-1:0] out_data;
  logic          in_ready0, out_valid0, out_idle0;
  logic [DW-1:0] out_data0;

  int n_cmp = 0;
  int n_err = 0;

  // Reference: serial LFSR per lane, s[0] = most recently sent stream bit.
  logic [57:0]   ms [NL];
  logic [DW-1:0] orig [NBEATS];
  logic [DW-1:0] scr_seen [NBEATS];

  always #5 clk = ~clk;

  multi_lane_scrambler #(.NUM_LANES(NL), .LANE_W(W), .RESET_SEED(SEED)) dut (
    .clk(clk), .reset(reset), .in_enable(in_enable), .mode(mode), .lane_mask(lane_mask),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready),
`ifdef SCR_SEED_LOAD_EN
    .seed_load(1'b0), .seed_value(58'h0),
`endif
    .in_idle(in_idle), .out_idle(out_idle)
  );

  multi_lane_scrambler #(.NUM_LANES(NL), .LANE_W(W), .RESET_SEED(58'h0)) dut0 (
    .clk(clk), .reset(reset), .in_enable(in_enable), .mode(mode), .lane_mask(lane_mask),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready0), .out_data(out_data0),
    .out_valid(out_valid0), .out_ready(out_ready),
`ifdef SCR_SEED_LOAD_EN
    .seed_load(1'b0), .seed_value(58'h0),
`endif
    .in_idle(in_idle), .out_idle(out_idle0)
  );

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  task automatic model_reset();
    for (int l = 0; l < NL; l++) ms[l] = SEED;
  endtask

  task automatic model_beat(input logic [DW-1:0] d, input logic m, input logic en,
                            input logic [NL-1:0] mask, output logic [DW-1:0] y);
    logic db, yb;
    y = d;
    for (int l = 0; l < NL; l++) begin
      if (en && mask[l]) begin
        for (int i = 0; i < W; i++) begin
          db = d[l*W+i];
          yb = db ^ ms[l][38] ^ ms[l][57];
          y[l*W+i] = yb;
          ms[l] = {ms[l][56:0], (m ? db : yb)};
        end
      end
    end
  endtask

  function automatic logic [DW-1:0] rand_dw();
    logic [DW-1:0] v;
    for (int k = 0; k < DW / 32; k++) v[k*32 +: 32] = $urandom;
    return v;
  endfunction

  // Called #1 after a posedge; the beat is accepted on the next posedge.
  task automatic send(input string tag, input logic [DW-1:0] d, input logic m, input logic en,
                      input logic [NL-1:0] mask, output logic [DW-1:0] expv);
    in_data = d; mode = m; in_enable = en; lane_mask = mask; in_valid = 1'b1;
    model_beat(d, m, en, mask, expv);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({tag, "_valid"}, DW'(out_valid), DW'(1'b1));
    chk(tag, out_data, expv);
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    reset = 1'b1;
    #12;
    reset = 1'b0;
    model_reset();
    @(posedge clk); #1;
  endtask

  initial begin
    logic [DW-1:0] e, ea;
    logic [DW-1:0] dead;
    dead = {NL{64'hDEAD_BEEF_0123_4567}};

    // Reset state and idle passthrough during reset
    #2;
    chk("rst_valid", DW'(out_valid), '0);
    chk("rst_data", out_data, '0);
    chk("rst_ready", DW'(in_ready), DW'(1'b1));
    in_idle = 1'b1; #1;
    chk("idle_in_reset", DW'(out_idle), DW'(1'b1));
    do_reset();
    in_idle = 1'b0; #1;
    chk("idle_low", DW'(out_idle), '0);

    // Zero data: zero-seeded instance stays zero, default-seed instance follows the model
    for (int b = 0; b < 4; b++) begin
      send("zero_main", '0, 1'b0, 1'b1, '1, e);
      chk("zero_seed0_valid", DW'(out_valid0), DW'(1'b1));
      chk("zero_seed0", out_data0, '0);
    end
    @(posedge clk); #1;
    chk("drain_valid", DW'(out_valid), '0);

    // Global disable: exact passthrough, state untouched
    for (int b = 0; b < 3; b++) send("disabled", dead, 1'b0, 1'b0, '1, e);
    chk("disabled_eq_in", out_data, dead);
    for (int b = 0; b < 3; b++) send("reenabled", rand_dw(), 1'b0, 1'b1, '1, e);

    // Mixed random modes
    for (int b = 0; b < 20; b++) send("rand_mode", rand_dw(), 1'($urandom), 1'b1, '1, e);

    // Lane mask 0101 with all-ones data, then unmask
    for (int b = 0; b < 3; b++) send("mask0101", '1, 1'b0, 1'b1, 4'b0101, e);
    chk("mask_lane1_ones", DW'(out_data[W +: W]), DW'({W{1'b1}}));
    chk("mask_lane3_ones", DW'(out_data[3*W +: W]), DW'({W{1'b1}}));
    for (int b = 0; b < 4; b++) send("unmask", rand_dw(), 1'b0, 1'b1, '1, e);

    // Backpressure: stall 5 cycles with a beat pending
    send("bp_a", rand_dw(), 1'b0, 1'b1, '1, ea);
    out_ready = 1'b0;
    in_data = rand_dw(); in_valid = 1'b1;
    #1;
    chk("bp_ready_low", DW'(in_ready), '0);
    for (int c = 0; c < 5; c++) begin
      mode = 1'b1; lane_mask = 4'($urandom); in_enable = 1'($urandom);
      @(posedge clk); #1;
      chk("bp_valid_held", DW'(out_valid), DW'(1'b1));
      chk("bp_data_held", out_data, ea);
      chk("bp_ready", DW'(in_ready), '0);
    end
    mode = 1'b0; lane_mask = '1; in_enable = 1'b1;
    out_ready = 1'b1;
    model_beat(in_data, 1'b0, 1'b1, '1, e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("bp_b", out_data, e);
    for (int b = 0; b < 3; b++) send("bp_after", rand_dw(), 1'b0, 1'b1, '1, e);

    // Reset pulse while a beat is being accepted
    in_data = rand_dw(); in_valid = 1'b1;
    #3;
    reset = 1'b1;
    #1;
    chk("rstpulse_valid", DW'(out_valid), '0);
    chk("rstpulse_data", out_data, '0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b0;
    model_reset();
    for (int b = 0; b < 2; b++) send("after_rst", rand_dw(), 1'b0, 1'b1, '1, e);

    // Loopback: scramble a stream, then descramble the DUT's own output from the same seed
    do_reset();
    for (int b = 0; b < NBEATS; b++) begin
      orig[b] = rand_dw();
      send("lb_scr", orig[b], 1'b0, 1'b1, '1, e);
      scr_seen[b] = out_data;
    end
    do_reset();
    for (int b = 0; b < NBEATS; b++) begin
      send("lb_dscr", scr_seen[b], 1'b1, 1'b1, '1, e);
      chk("lb_orig", out_data, orig[b]);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
